// File: rtl/writeback_unit.sv
// Writeback stage: formats ALU/load results into a small circular queue and
// commits up to LANES entries per cycle to the register file.
module writeback_unit #(
    parameter int LANES  = 2,
    parameter int QDEPTH = 4,
    parameter int XLEN   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [LANES-1:0]      in_valid,
    output logic                  in_ready,
    input  logic [LANES*XLEN-1:0] in_pc,
    input  logic [LANES*5-1:0]    in_dst,
    input  logic [LANES-1:0]      in_wen,
    input  logic [LANES-1:0]      in_isload,
    input  logic [LANES*2-1:0]    in_msize,
    input  logic [LANES-1:0]      in_msext,
    input  logic [LANES*3-1:0]    in_addr_lo,
    input  logic [LANES*XLEN-1:0] in_alu,
    input  logic [LANES*XLEN-1:0] in_mrd,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_valid,
    output logic [LANES-1:0]      out_wen,
    output logic [LANES*5-1:0]    out_dst,
    output logic [LANES*XLEN-1:0] out_data,
    output logic [LANES*XLEN-1:0] out_pc,
    output logic [63:0]           instret
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] q_pc   [QDEPTH];
    logic [XLEN-1:0] q_data [QDEPTH];
    logic [4:0]      q_dst  [QDEPTH];
    logic            q_wen  [QDEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [LANES-1:0] push_en;
    logic [PW-1:0]    push_idx [LANES];
    logic [CW-1:0]    push_cnt;
    logic [CW-1:0]    pop_cnt;

    // Misaligned low address bits are dropped according to access size.
    function automatic logic [XLEN-1:0] lane_result(
        input logic            isload,
        input logic [1:0]      msize,
        input logic            msext,
        input logic [2:0]      addr_lo,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] mrd
    );
        logic [2:0]      off;
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        case (msize)
            2'b00:   off = addr_lo;
            2'b01:   off = {addr_lo[2:1], 1'b0};
            2'b10:   off = {addr_lo[2], 2'b00};
            default: off = 3'b000;
        endcase
        sh = mrd >> {off, 3'b000};
        case (msize)
            2'b00:   res = {{(XLEN-8){msext & sh[7]}}, sh[7:0]};
            2'b01:   res = {{(XLEN-16){msext & sh[15]}}, sh[15:0]};
            2'b10:   res = {{(XLEN-32){msext & sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return isload ? res : alu;
    endfunction

    assign in_ready = (CW'(QDEPTH) - count) >= CW'(LANES);

    // Valid lanes are packed into consecutive slots starting at tail.
    always_comb begin
        push_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            push_en[l]  = in_ready & in_valid[l] & ~flush;
            push_idx[l] = tail + PW'(push_cnt);
            if (push_en[l]) begin
                push_cnt = push_cnt + CW'(1);
            end
        end
        pop_cnt = '0;
        if (out_ready && !flush) begin
            pop_cnt = (count < CW'(LANES)) ? count : CW'(LANES);
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (push_en[l]) begin
                q_pc[push_idx[l]]   <= in_pc[l*XLEN +: XLEN];
                q_dst[push_idx[l]]  <= in_dst[l*5 +: 5];
                q_wen[push_idx[l]]  <= in_wen[l];
                q_data[push_idx[l]] <= lane_result(in_isload[l], in_msize[l*2 +: 2],
                                                   in_msext[l], in_addr_lo[l*3 +: 3],
                                                   in_alu[l*XLEN +: XLEN],
                                                   in_mrd[l*XLEN +: XLEN]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            instret <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head    <= head + PW'(pop_cnt);
            tail    <= tail + PW'(push_cnt);
            count   <= count + push_cnt - pop_cnt;
            instret <= instret + 64'(pop_cnt);
        end
    end

    // Empty slots present zeros so the register file never sees stale data.
    always_comb begin
        out_valid = '0;
        out_wen   = '0;
        out_dst   = '0;
        out_data  = '0;
        out_pc    = '0;
        for (int k = 0; k < LANES; k++) begin
            if (count > CW'(k)) begin
                out_valid[k]            = 1'b1;
                out_wen[k]              = q_wen[head + PW'(k)] & (q_dst[head + PW'(k)] != 5'd0);
                out_dst[k*5 +: 5]       = q_dst[head + PW'(k)];
                out_data[k*XLEN +: XLEN] = q_data[head + PW'(k)];
                out_pc[k*XLEN +: XLEN]   = q_pc[head + PW'(k)];
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (LANES=2, QDEPTH=4, XLEN=64).
module tb_writeback_unit;

    logic         clk;
    logic         reset;
    logic         flush;
    logic [1:0]   in_valid;
    logic         in_ready;
    logic [127:0] in_pc;
    logic [9:0]   in_dst;
    logic [1:0]   in_wen;
    logic [1:0]   in_isload;
    logic [3:0]   in_msize;
    logic [1:0]   in_msext;
    logic [5:0]   in_addr_lo;
    logic [127:0] in_alu;
    logic [127:0] in_mrd;
    logic         out_ready;
    logic [1:0]   out_valid;
    logic [1:0]   out_wen;
    logic [9:0]   out_dst;
    logic [127:0] out_data;
    logic [127:0] out_pc;
    logic [63:0]  instret;

    int compared;
    int mismatched;
    logic [63:0] exp_instret;

    writeback_unit #(.LANES(2), .QDEPTH(4), .XLEN(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_dst(in_dst),
        .in_wen(in_wen), .in_isload(in_isload), .in_msize(in_msize), .in_msext(in_msext),
        .in_addr_lo(in_addr_lo), .in_alu(in_alu), .in_mrd(in_mrd), .out_ready(out_ready),
        .out_valid(out_valid), .out_wen(out_wen), .out_dst(out_dst), .out_data(out_data),
        .out_pc(out_pc), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush      = 1'b0;
        in_valid   = '0;
        in_pc      = '0;
        in_dst     = '0;
        in_wen     = '0;
        in_isload  = '0;
        in_msize   = '0;
        in_msext   = '0;
        in_addr_lo = '0;
        in_alu     = '0;
        in_mrd     = '0;
    endtask

    task automatic set_lane(input int l, input logic [63:0] pc, input logic [4:0] dst,
                            input logic wen, input logic [63:0] alu);
        in_pc[l*64 +: 64]  = pc;
        in_dst[l*5 +: 5]   = dst;
        in_wen[l]          = wen;
        in_isload[l]       = 1'b0;
        in_alu[l*64 +: 64] = alu;
    endtask

    task automatic set_load(input int l, input logic [1:0] msize, input logic msext,
                            input logic [2:0] addr, input logic [63:0] mrd);
        in_isload[l]          = 1'b1;
        in_msize[l*2 +: 2]    = msize;
        in_msext[l]           = msext;
        in_addr_lo[l*3 +: 3]  = addr;
        in_mrd[l*64 +: 64]    = mrd;
    endtask

    task automatic test_reset();
        clear_inputs();
        out_ready = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        compared++;
        if (out_valid !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_out_valid got %b expected 00", out_valid);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready);
        end
        compared++;
        if (instret !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_instret got %0d expected 0", instret);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL release_state got ready=%b valid=%b expected 1/00", in_ready, out_valid);
        end
        exp_instret = 64'd0;
    endtask

    task automatic test_alu();
        clear_inputs();
        out_ready = 1'b1;
        set_lane(0, 64'h8000_0000, 5'd5, 1'b1, 64'h1234);
        in_valid = 2'b01;
        tick();
        clear_inputs();
        compared++;
        if (out_valid !== 2'b01 || out_wen !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL alu_valid_wen got %b/%b expected 01/01", out_valid, out_wen);
        end
        compared++;
        if (out_data[63:0] !== 64'h1234 || out_pc[63:0] !== 64'h8000_0000 || out_dst[4:0] !== 5'd5) begin
            mismatched++;
            $display("[TB] FAIL alu_slot0 got data=%h pc=%h dst=%0d expected 1234/80000000/5",
                     out_data[63:0], out_pc[63:0], out_dst[4:0]);
        end
        compared++;
        if (out_data[127:64] !== 64'd0 || out_pc[127:64] !== 64'd0 || out_dst[9:5] !== 5'd0) begin
            mismatched++;
            $display("[TB] FAIL alu_slot1_zero got data=%h pc=%h dst=%0d expected 0",
                     out_data[127:64], out_pc[127:64], out_dst[9:5]);
        end
        tick();
        exp_instret = exp_instret + 1;
        compared++;
        if (instret !== exp_instret || out_valid !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL alu_retire got instret=%0d valid=%b expected %0d/00", instret, out_valid, exp_instret);
        end
    endtask

    task automatic test_load();
        logic [1:0]  sz   [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
        logic        sx   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  ad   [6] = '{3'd7, 3'd7, 3'd3, 3'd6, 3'd6, 3'd5};
        logic [63:0] mrd  [6] = '{64'h80FF_0000_0000_0000, 64'h80FF_0000_0000_0000,
                                  64'h0000_0000_F00D_0000, 64'h8765_4321_0000_0000,
                                  64'h8765_4321_0000_0000, 64'h0123_4567_89AB_CDEF};
        logic [63:0] want [6] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080,
                                  64'hFFFF_FFFF_FFFF_F00D, 64'h0000_0000_8765_4321,
                                  64'hFFFF_FFFF_8765_4321, 64'h0123_4567_89AB_CDEF};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            set_lane(0, 64'h200 + 64'(i), 5'd10, 1'b1, 64'hDEAD);
            set_load(0, sz[i], sx[i], ad[i], mrd[i]);
            in_valid = 2'b01;
            tick();
            clear_inputs();
            compared++;
            if (out_valid !== 2'b01 || out_data[63:0] !== want[i]) begin
                mismatched++;
                $display("[TB] FAIL load_%0d got valid=%b data=%h expected 01/%h", i, out_valid, out_data[63:0], want[i]);
            end
            tick();
            exp_instret = exp_instret + 1;
        end
        compared++;
        if (instret !== exp_instret) begin
            mismatched++;
            $display("[TB] FAIL load_instret got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_x0_gap();
        clear_inputs();
        out_ready = 1'b1;
        set_lane(0, 64'h300, 5'd0, 1'b1, 64'h55);
        in_valid = 2'b01;
        tick();
        clear_inputs();
        compared++;
        if (out_valid !== 2'b01 || out_wen !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL x0_write got valid=%b wen=%b expected 01/00", out_valid, out_wen);
        end
        tick();
        exp_instret = exp_instret + 1;
        compared++;
        if (instret !== exp_instret) begin
            mismatched++;
            $display("[TB] FAIL x0_instret got %0d expected %0d", instret, exp_instret);
        end
        set_lane(0, 64'h400, 5'd9, 1'b1, 64'hEE);
        set_lane(1, 64'h404, 5'd7, 1'b1, 64'hAB);
        in_valid = 2'b10;
        tick();
        clear_inputs();
        compared++;
        if (out_valid !== 2'b01 || out_wen !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL gap_valid got valid=%b wen=%b expected 01/01", out_valid, out_wen);
        end
        compared++;
        if (out_pc[63:0] !== 64'h404 || out_dst[4:0] !== 5'd7 || out_data[63:0] !== 64'hAB) begin
            mismatched++;
            $display("[TB] FAIL gap_slot0 got pc=%h dst=%0d data=%h expected 404/7/ab",
                     out_pc[63:0], out_dst[4:0], out_data[63:0]);
        end
        tick();
        exp_instret = exp_instret + 1;
    endtask

    task automatic test_backpressure();
        clear_inputs();
        out_ready = 1'b0;
        set_lane(0, 64'hA0, 5'd1, 1'b1, 64'h10);
        set_lane(1, 64'hA4, 5'd2, 1'b1, 64'h11);
        in_valid = 2'b11;
        tick();
        compared++;
        if (out_valid !== 2'b11 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_first got valid=%b ready=%b expected 11/1", out_valid, in_ready);
        end
        set_lane(0, 64'hB0, 5'd3, 1'b1, 64'h12);
        set_lane(1, 64'hB4, 5'd4, 1'b1, 64'h13);
        tick();
        compared++;
        if (in_ready !== 1'b0 || out_pc[63:0] !== 64'hA0 || out_pc[127:64] !== 64'hA4) begin
            mismatched++;
            $display("[TB] FAIL bp_full got ready=%b pc0=%h pc1=%h expected 0/a0/a4",
                     in_ready, out_pc[63:0], out_pc[127:64]);
        end
        set_lane(0, 64'hC0, 5'd5, 1'b1, 64'h14);
        set_lane(1, 64'hC4, 5'd6, 1'b1, 64'h15);
        tick();
        compared++;
        if (in_ready !== 1'b0 || out_pc[63:0] !== 64'hA0 || out_data[127:64] !== 64'h11 || instret !== exp_instret) begin
            mismatched++;
            $display("[TB] FAIL bp_stall got ready=%b pc0=%h data1=%h instret=%0d expected 0/a0/11/%0d",
                     in_ready, out_pc[63:0], out_data[127:64], instret, exp_instret);
        end
        out_ready = 1'b1;
        tick();
        exp_instret = exp_instret + 2;
        compared++;
        if (in_ready !== 1'b1 || out_pc[63:0] !== 64'hB0 || out_pc[127:64] !== 64'hB4 || instret !== exp_instret) begin
            mismatched++;
            $display("[TB] FAIL bp_pop got ready=%b pc0=%h pc1=%h instret=%0d expected 1/b0/b4/%0d",
                     in_ready, out_pc[63:0], out_pc[127:64], instret, exp_instret);
        end
        tick();
        exp_instret = exp_instret + 2;
        compared++;
        if (out_pc[63:0] !== 64'hC0 || out_pc[127:64] !== 64'hC4 || out_valid !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL bp_pushpop got pc0=%h pc1=%h valid=%b expected c0/c4/11",
                     out_pc[63:0], out_pc[127:64], out_valid);
        end
        clear_inputs();
        tick();
        exp_instret = exp_instret + 2;
        compared++;
        if (out_valid !== 2'b00 || instret !== exp_instret) begin
            mismatched++;
            $display("[TB] FAIL bp_drain got valid=%b instret=%0d expected 00/%0d", out_valid, instret, exp_instret);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        out_ready = 1'b0;
        set_lane(0, 64'hD0, 5'd1, 1'b1, 64'h1);
        set_lane(1, 64'hD4, 5'd2, 1'b1, 64'h2);
        in_valid = 2'b11;
        tick();
        in_valid = 2'b01;
        tick();
        compared++;
        if (out_valid !== 2'b11 || in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL flush_setup got valid=%b ready=%b expected 11/0", out_valid, in_ready);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 2'b11;
        tick();
        compared++;
        if (out_valid !== 2'b00 || in_ready !== 1'b1 || instret !== exp_instret) begin
            mismatched++;
            $display("[TB] FAIL flush_clear got valid=%b ready=%b instret=%0d expected 00/1/%0d",
                     out_valid, in_ready, instret, exp_instret);
        end
        tick();
        compared++;
        if (out_valid !== 2'b00 || instret !== exp_instret) begin
            mismatched++;
            $display("[TB] FAIL flush_blocks_push got valid=%b instret=%0d expected 00/%0d",
                     out_valid, instret, exp_instret);
        end
        clear_inputs();
        tick();
        compared++;
        if (out_valid !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL flush_after got valid=%b expected 00", out_valid);
        end
    endtask

    task automatic test_midreset();
        clear_inputs();
        out_ready = 1'b0;
        set_lane(0, 64'hE0, 5'd1, 1'b1, 64'h1);
        set_lane(1, 64'hE4, 5'd2, 1'b1, 64'h2);
        in_valid = 2'b11;
        tick();
        clear_inputs();
        reset = 1'b0;
        #1;
        compared++;
        if (out_valid !== 2'b00 || out_wen !== 2'b00 || instret !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_async got valid=%b wen=%b instret=%0d expected 00/00/0",
                     out_valid, out_wen, instret);
        end
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        exp_instret = 64'd0;
        compared++;
        if (out_valid !== 2'b00 || instret !== 64'd0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset_discard got valid=%b instret=%0d ready=%b expected 00/0/1",
                     out_valid, instret, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_lane(0, 64'h1000 + 64'(8 * i), 5'd3, 1'b1, 64'(i));
            set_lane(1, 64'h1004 + 64'(8 * i), 5'd4, 1'b1, 64'(i + 100));
            in_valid = 2'b11;
            tick();
            compared++;
            if (out_valid !== 2'b11 || out_pc[63:0] !== 64'h1000 + 64'(8 * i) ||
                out_pc[127:64] !== 64'h1004 + 64'(8 * i)) begin
                mismatched++;
                $display("[TB] FAIL wrap_cycle%0d got valid=%b pc0=%h pc1=%h expected 11/%h/%h", i,
                         out_valid, out_pc[63:0], out_pc[127:64],
                         64'h1000 + 64'(8 * i), 64'h1004 + 64'(8 * i));
            end
        end
        clear_inputs();
        tick();
        exp_instret = exp_instret + 20;
        compared++;
        if (out_valid !== 2'b00 || instret !== 64'd20) begin
            mismatched++;
            $display("[TB] FAIL wrap_drain got valid=%b instret=%0d expected 00/20", out_valid, instret);
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        exp_instret = 64'd0;
        reset       = 1'b0;
        out_ready   = 1'b0;
        clear_inputs();
        test_reset();
        test_alu();
        test_load();
        test_x0_gap();
        test_backpressure();
        test_flush();
        test_midreset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
